mem_copy_engine: RTL and testbench

Memory-side initiator for the `ideal_mem` word memory of the MIPS evaluation platform. On a start command it copies `len` consecutive words from a source word index to a destination word index through the memory's read port 1 and write port, accumulating a 32-bit wrap-around checksum of the copied data. It sits beside the CPU core in the test harness and bulk-initialises or relocates program/data regions before the core is released.

---
 rtl/mem_copy_engine_pkg.sv | 29 ++
 rtl/mem_copy_engine_if.sv | 23 ++
 rtl/mem_copy_engine.sv | 122 ++++++++++++
 tb/tb_mem_copy_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for harness memory initiators.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_copy_engine_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;

  // 3-bit state encodings shared with the other harness initiators
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE,
    S_ABORT = ST_ABORT
  } copy_state_t;

  // Next word index, wrapping back to 0 past the last addressable word
  function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned mem_width);
    if (idx + 1 >= mem_width) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Word-memory access bus: one read port and one write port of ideal_mem.
// Latency: read data is combinational from the read address.
// Backpressure: none; the memory accepts every access in the cycle it is issued.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] Raddr1;
  logic                  Rden1;
  logic [31:0]           Rdata1;
  logic [ADDR_WIDTH-1:0] Waddr;
  logic                  Wren;
  logic [31:0]           Wdata;

  modport master (
    output Raddr1, Rden1, Waddr, Wren, Wdata,
    input  Rdata1
  );

  modport slave (
    input  Raddr1, Rden1, Waddr, Wren, Wdata,
    output Rdata1
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Copies len words from src to dst index through the memory bus, summing the data read.
// Latency: two cycles per word (read then write) plus one DONE cycle; len=0 finishes in one.
// Backpressure: none from memory; start ignored while busy, abort terminates a copy in flight.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MEM_WIDTH  = 2 ** (ADDR_WIDTH - 2),
  parameter int LEN_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [31:0]           checksum,
  output logic [LEN_WIDTH-1:0]  words_done,
  mem_copy_engine_if.master     mem
);

  copy_state_t           state, state_nx;
  logic [ADDR_WIDTH-1:0] src_idx, dst_idx;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [31:0]           data_r;
  logic [LEN_WIDTH:0]    wd_inc;

  // One extra bit so the "more words left" compare cannot overflow
  assign wd_inc = {1'b0, words_done} + {{LEN_WIDTH{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and bus/status outputs; memory strobes are zero outside their state
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    mem.Rden1  = 1'b0;
    mem.Raddr1 = '0;
    mem.Wren   = 1'b0;
    mem.Waddr  = '0;
    mem.Wdata  = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = (len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        busy       = 1'b1;
        mem.Rden1  = 1'b1;
        mem.Raddr1 = src_idx;
        state_nx   = abort ? S_ABORT : S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem.Wren  = ~abort;
        mem.Waddr = dst_idx;
        mem.Wdata = data_r;
        if (abort)                     state_nx = S_ABORT;
        else if (wd_inc < {1'b0, len_r}) state_nx = S_READ;
        else                           state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ABORT: begin
        aborted  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command latch, word pointers, data holding register and running statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_idx    <= '0;
      dst_idx    <= '0;
      len_r      <= '0;
      data_r     <= '0;
      checksum   <= '0;
      words_done <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_idx    <= ADDR_WIDTH'(32'(src) % MEM_WIDTH);
            dst_idx    <= ADDR_WIDTH'(32'(dst) % MEM_WIDTH);
            len_r      <= len;
            checksum   <= '0;
            words_done <= '0;
          end
        end
        S_READ: begin
          if (!abort) begin
            data_r   <= mem.Rdata1;
            checksum <= checksum + mem.Rdata1;
            src_idx  <= ADDR_WIDTH'(idx_inc(32'(src_idx), MEM_WIDTH));
          end
        end
        S_WRITE: begin
          if (!abort) begin
            words_done <= wd_inc[LEN_WIDTH-1:0];
            dst_idx    <= ADDR_WIDTH'(idx_inc(32'(dst_idx), MEM_WIDTH));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine paired with a behavioural 256-word memory.
// Latency: cycle numbers counted from the start cycle (cycle 0).
// Backpressure: n/a.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  src = '0;
  logic [9:0]  dst = '0;
  logic [8:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [31:0] checksum;
  logic [8:0]  words_done;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_dat = '0;

  int n_checks = 0;
  int n_fail = 0;

  mem_copy_engine_if #(.ADDR_WIDTH(10)) bus ();

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .checksum(checksum),
    .words_done(words_done), .mem(bus)
  );

  always #5 clk = ~clk;

  assign bus.Rdata1 = mem[bus.Raddr1[7:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (bus.Wren) mem[bus.Waddr[7:0]] <= bus.Wdata;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue a command in cycle 0 and observe cycles 1..2n+4 on the falling edge.
  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [8:0] n,
                          input int abort_at, input int restart_at,
                          output int done_c, output int abort_c, output int wren_cnt,
                          output int rden_cnt, output int busy_cnt);
    done_c = -1; abort_c = -1; wren_cnt = 0; rden_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src = 10'h3FF; dst = 10'h3FE; len = 9'd1;
    for (int c = 1; c <= 2 * int'(n) + 4; c++) begin
      abort = (c == abort_at);
      if (c == restart_at) begin
        start = 1'b1; src = 10'd60; dst = 10'd61; len = 9'd7;
      end
      @(negedge clk);
      if (done && done_c < 0) done_c = c;
      if (aborted && abort_c < 0) abort_c = c;
      if (bus.Wren) wren_cnt++;
      if (bus.Rden1) rden_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || aborted !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b want 00", done, aborted); end
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL reset_checksum got %h want 0", checksum); end
    n_checks++; if (words_done !== 9'd0) begin n_fail++; $display("FAIL reset_words_done got %0d want 0", words_done); end
    n_checks++; if (bus.Rden1 !== 1'b0 || bus.Wren !== 1'b0 || bus.Raddr1 !== 10'd0 || bus.Waddr !== 10'd0 || bus.Wdata !== 32'd0)
      begin n_fail++; $display("FAIL reset_bus got rden=%b wren=%b raddr=%0d waddr=%0d wdata=%h want all 0", bus.Rden1, bus.Wren, bus.Raddr1, bus.Waddr, bus.Wdata); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int dc, ac, wc, rc, bc;
    for (int i = 0; i < 4; i++) preload(8'(4 + i), 32'(i + 1));
    for (int i = 0; i < 4; i++) preload(8'(40 + i), 32'hDEAD0000);
    run_copy(10'd4, 10'd40, 9'd4, -1, -1, dc, ac, wc, rc, bc);
    n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 9", dc); end
    n_checks++; if (checksum !== 32'd10) begin n_fail++; $display("FAIL basic_checksum got %0d want 10", checksum); end
    n_checks++; if (words_done !== 9'd4) begin n_fail++; $display("FAIL basic_words_done got %0d want 4", words_done); end
    n_checks++; if (bc !== 9) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
    n_checks++; if (wc !== 4 || rc !== 4) begin n_fail++; $display("FAIL basic_access_count got wr=%0d rd=%0d want 4 4", wc, rc); end
    n_checks++; if (ac !== -1) begin n_fail++; $display("FAIL basic_no_abort got %0d want -1", ac); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[40 + i] !== 32'(i + 1)) begin n_fail++; $display("FAIL basic_mem[%0d] got %h want %h", 40 + i, mem[40 + i], 32'(i + 1)); end
    end
  endtask

  task automatic test_zero_len;
    int dc, ac, wc, rc, bc;
    run_copy(10'd4, 10'd50, 9'd0, -1, -1, dc, ac, wc, rc, bc);
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
    n_checks++; if (wc !== 0 || rc !== 0) begin n_fail++; $display("FAIL zero_no_access got wr=%0d rd=%0d want 0 0", wc, rc); end
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL zero_checksum got %h want 0", checksum); end
    n_checks++; if (words_done !== 9'd0) begin n_fail++; $display("FAIL zero_words_done got %0d want 0", words_done); end
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 1", bc); end
  endtask

  task automatic test_wrap;
    int dc, ac, wc, rc, bc;
    preload(8'd254, 32'hFFFFFFFF);
    preload(8'd255, 32'd1);
    preload(8'd0, 32'd5);
    run_copy(10'd254, 10'd10, 9'd3, -1, -1, dc, ac, wc, rc, bc);
    n_checks++; if (dc !== 7) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 7", dc); end
    n_checks++; if (checksum !== 32'd5) begin n_fail++; $display("FAIL wrap_checksum got %h want 5", checksum); end
    n_checks++; if (mem[10] !== 32'hFFFFFFFF || mem[11] !== 32'd1 || mem[12] !== 32'd5)
      begin n_fail++; $display("FAIL wrap_mem got %h %h %h want ffffffff 1 5", mem[10], mem[11], mem[12]); end
  endtask

  task automatic test_dst_wrap;
    int dc, ac, wc, rc, bc;
    preload(8'd1, 32'h0);
    run_copy(10'd4, 10'd255, 9'd2, -1, -1, dc, ac, wc, rc, bc);
    n_checks++; if (mem[255] !== 32'd1 || mem[0] !== 32'd2)
      begin n_fail++; $display("FAIL dst_wrap_mem got %h %h want 1 2", mem[255], mem[0]); end
    n_checks++; if (mem[1] !== 32'd0) begin n_fail++; $display("FAIL dst_wrap_overrun got %h want 0", mem[1]); end
  endtask

  task automatic test_overlap;
    int dc, ac, wc, rc, bc;
    preload(8'd20, 32'hA);
    preload(8'd21, 32'h11);
    preload(8'd22, 32'h22);
    preload(8'd23, 32'h33);
    run_copy(10'd20, 10'd21, 9'd3, -1, -1, dc, ac, wc, rc, bc);
    n_checks++; if (mem[21] !== 32'hA || mem[22] !== 32'hA || mem[23] !== 32'hA)
      begin n_fail++; $display("FAIL overlap_mem got %h %h %h want a a a", mem[21], mem[22], mem[23]); end
    n_checks++; if (checksum !== 32'h1E) begin n_fail++; $display("FAIL overlap_checksum got %h want 1e", checksum); end
  endtask

  task automatic test_abort;
    int dc, ac, wc, rc, bc;
    for (int i = 0; i < 4; i++) preload(8'(60 + i), 32'(7 + i));
    for (int i = 0; i < 4; i++) preload(8'(80 + i), 32'd0);
    run_copy(10'd60, 10'd80, 9'd4, 4, -1, dc, ac, wc, rc, bc);
    n_checks++; if (ac !== 5) begin n_fail++; $display("FAIL abort_cycle got %0d want 5", ac); end
    n_checks++; if (dc !== -1) begin n_fail++; $display("FAIL abort_no_done got %0d want -1", dc); end
    n_checks++; if (words_done !== 9'd1) begin n_fail++; $display("FAIL abort_words_done got %0d want 1", words_done); end
    n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL abort_writes got %0d want 1", wc); end
    n_checks++; if (checksum !== 32'd15) begin n_fail++; $display("FAIL abort_checksum got %0d want 15", checksum); end
    n_checks++; if (mem[80] !== 32'd7 || mem[81] !== 32'd0)
      begin n_fail++; $display("FAIL abort_mem got %h %h want 7 0", mem[80], mem[81]); end
  endtask

  task automatic test_start_while_busy;
    int dc, ac, wc, rc, bc;
    preload(8'd100, 32'h55);
    preload(8'd101, 32'h66);
    preload(8'd62, 32'h0);
    run_copy(10'd100, 10'd110, 9'd2, -1, 2, dc, ac, wc, rc, bc);
    n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL busy_start_done_cycle got %0d want 5", dc); end
    n_checks++; if (mem[110] !== 32'h55 || mem[111] !== 32'h66)
      begin n_fail++; $display("FAIL busy_start_mem got %h %h want 55 66", mem[110], mem[111]); end
    n_checks++; if (checksum !== 32'hBB || wc !== 2)
      begin n_fail++; $display("FAIL busy_start_ignored got sum=%h wr=%0d want bb 2", checksum, wc); end
    n_checks++; if (mem[62] !== 32'h0) begin n_fail++; $display("FAIL busy_start_stray_write got %h want 0", mem[62]); end
  endtask

  task automatic test_reset_mid_copy;
    int pulses;
    preload(8'd200, 32'd0);
    preload(8'd201, 32'd0);
    @(negedge clk);
    src = 10'd4; dst = 10'd200; len = 9'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    n_checks++; if (busy !== 1'b0 || bus.Rden1 !== 1'b0 || bus.Raddr1 !== 10'd0)
      begin n_fail++; $display("FAIL rst_mid_outputs got busy=%b rden=%b raddr=%0d want 0", busy, bus.Rden1, bus.Raddr1); end
    n_checks++; if (checksum !== 32'd0 || words_done !== 9'd0)
      begin n_fail++; $display("FAIL rst_mid_stats got sum=%0d wd=%0d want 0 0", checksum, words_done); end
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (aborted || done || busy || bus.Wren) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", pulses); end
    n_checks++; if (mem[200] !== 32'd1 || mem[201] !== 32'd0)
      begin n_fail++; $display("FAIL rst_mid_mem got %h %h want 1 0", mem[200], mem[201]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_dst_wrap();
    test_overlap();
    test_abort();
    test_start_while_busy();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
